switch_level: RTL and testbench



---
 rtl/switch_level.sv | 70 +++++++
 tb/tb_switch_level.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_level.sv
// 1-bit full adder whose core is a static CMOS mirror adder built from MOS
// switch primitives, with the carry and sum captured in an output register.
module switch_level (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic Y1,
    output logic Y0
);

    supply1 vdd;
    supply0 gnd;

    wire nco;
    wire ns;
    wire carry;
    wire sum;
    wire cn1, cn2, cp1, cp2;
    wire sn1, sn2, sn3, sp1, sp2, sp3;

    // Carry gate: nco = ~(a&b | c&(a|b)).
    // The pull-up network mirrors the pull-down network.
    nmos cn_a  (nco, cn1, a);
    nmos cn_b  (cn1, gnd, b);
    nmos cn_c  (nco, cn2, c);
    nmos cn_pa (cn2, gnd, a);
    nmos cn_pb (cn2, gnd, b);

    pmos cp_a  (nco, cp1, a);
    pmos cp_b  (cp1, vdd, b);
    pmos cp_c  (nco, cp2, c);
    pmos cp_pa (cp2, vdd, a);
    pmos cp_pb (cp2, vdd, b);

    // Sum gate: ns = ~(a&b&c | nco&(a|b|c)).
    // It reuses the inverted carry from the carry gate.
    nmos sn_a  (ns, sn1, a);
    nmos sn_b  (sn1, sn2, b);
    nmos sn_c  (sn2, gnd, c);
    nmos sn_co (ns, sn3, nco);
    nmos sn_pa (sn3, gnd, a);
    nmos sn_pb (sn3, gnd, b);
    nmos sn_pc (sn3, gnd, c);

    pmos sp_a  (ns, sp1, a);
    pmos sp_b  (sp1, sp2, b);
    pmos sp_c  (sp2, vdd, c);
    pmos sp_co (ns, sp3, nco);
    pmos sp_pa (sp3, vdd, a);
    pmos sp_pb (sp3, vdd, b);
    pmos sp_pc (sp3, vdd, c);

    pmos ci_p (carry, vdd, nco);
    nmos ci_n (carry, gnd, nco);
    pmos si_p (sum, vdd, ns);
    nmos si_n (sum, gnd, ns);

    always_ff @(posedge clk) begin
        if (rst) begin
            Y1 <= 1'b0;
            Y0 <= 1'b0;
        end else begin
            Y1 <= carry;
            Y0 <= sum;
        end
    end

endmodule

// File: tb/tb_switch_level.sv
// Bench for switch_level: the reference model treats {Y1,Y0} as the 2-bit
// arithmetic count of ones among a, b and c.
module tb_switch_level;

    logic clk = 1'b0;
    logic rst;
    logic a, b, c;
    logic Y1, Y0;

    int checks = 0;
    int errors = 0;

    switch_level dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .c   (c),
        .Y1  (Y1),
        .Y0  (Y0)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] model(input logic [2:0] abc);
        int n;
        n = int'(abc[2]) + int'(abc[1]) + int'(abc[0]);
        return n[1:0];
    endfunction

    // Apply inputs, let one rising edge capture them, then settle past it.
    task automatic cyc(input logic [2:0] abc, input logic r);
        {a, b, c} = abc;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            cyc(3'b111, 1'b1);
            checks++;
            if ({Y1, Y0} !== 2'b00) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %b, expected 00", i, {Y1, Y0});
            end else begin
                $display("reset_hold cycle %0d: Y1Y0=%b", i, {Y1, Y0});
            end
        end
        cyc(3'b111, 1'b0);
        checks++;
        if ({Y1, Y0} !== model(3'b111)) begin
            errors++;
            $display("FAIL reset_release: got %b, expected %b", {Y1, Y0}, model(3'b111));
        end else begin
            $display("reset_release: Y1Y0=%b", {Y1, Y0});
        end
    endtask

    task automatic test_gray;
        logic [2:0] seq [9];
        seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                3'b111, 3'b101, 3'b100, 3'b000};
        for (int i = 0; i < 9; i++) begin
            cyc(seq[i], 1'b0);
            checks++;
            if ({Y1, Y0} !== model(seq[i])) begin
                errors++;
                $display("FAIL gray abc=%b: got %b, expected %b", seq[i], {Y1, Y0}, model(seq[i]));
            end else begin
                $display("gray abc=%b: Y1Y0=%b", seq[i], {Y1, Y0});
            end
        end
    endtask

    task automatic test_exhaustive;
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            cyc(v, 1'b0);
            checks++;
            if ({Y1, Y0} !== model(v)) begin
                errors++;
                $display("FAIL exhaustive abc=%b: got %b, expected %b", v, {Y1, Y0}, model(v));
            end else begin
                $display("exhaustive abc=%b: Y1Y0=%b", v, {Y1, Y0});
            end
        end
    endtask

    task automatic test_mid_reset;
        cyc(3'b011, 1'b0);
        checks++;
        if ({Y1, Y0} !== 2'b10) begin
            errors++;
            $display("FAIL mid_reset_pre: got %b, expected 10", {Y1, Y0});
        end else begin
            $display("mid_reset_pre: Y1Y0=%b", {Y1, Y0});
        end
        cyc(3'b011, 1'b1);
        checks++;
        if ({Y1, Y0} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_clear: got %b, expected 00", {Y1, Y0});
        end else begin
            $display("mid_reset_clear: Y1Y0=%b", {Y1, Y0});
        end
        cyc(3'b011, 1'b0);
        checks++;
        if ({Y1, Y0} !== model(3'b011)) begin
            errors++;
            $display("FAIL mid_reset_recover: got %b, expected %b", {Y1, Y0}, model(3'b011));
        end else begin
            $display("mid_reset_recover: Y1Y0=%b", {Y1, Y0});
        end
    endtask

    task automatic test_simultaneous;
        cyc(3'b000, 1'b0);
        cyc(3'b111, 1'b1);
        checks++;
        if ({Y1, Y0} !== 2'b00) begin
            errors++;
            $display("FAIL simul_reset_wins: got %b, expected 00", {Y1, Y0});
        end else begin
            $display("simul_reset_wins: Y1Y0=%b", {Y1, Y0});
        end
        cyc(3'b111, 1'b0);
        checks++;
        if ({Y1, Y0} !== 2'b11) begin
            errors++;
            $display("FAIL simul_release: got %b, expected 11", {Y1, Y0});
        end else begin
            $display("simul_release: Y1Y0=%b", {Y1, Y0});
        end
    endtask

    task automatic test_random;
        logic [2:0] v;
        logic       r;
        logic [1:0] exp;
        for (int i = 0; i < 40; i++) begin
            v = 3'($urandom_range(0, 7));
            r = ($urandom_range(0, 7) == 0);
            exp = r ? 2'b00 : model(v);
            cyc(v, r);
            checks++;
            if ({Y1, Y0} !== exp) begin
                errors++;
                $display("FAIL random abc=%b rst=%b: got %b, expected %b", v, r, {Y1, Y0}, exp);
            end else begin
                $display("random abc=%b rst=%b: Y1Y0=%b", v, r, {Y1, Y0});
            end
        end
    endtask

    task automatic test_x;
        logic exp_sum;
        cyc(3'b000, 1'b0);
        a = 1'bx;
        b = 1'b0;
        c = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        // With b=c=0 the sum equals a itself: X in a four-state simulator,
        // the resolved 0/1 value in a two-state one.
        exp_sum = a;
        checks++;
        if (Y0 !== exp_sum) begin
            errors++;
            $display("FAIL x_sum: got %b, expected %b", Y0, exp_sum);
        end else begin
            $display("x_sum: Y0=%b", Y0);
        end
        checks++;
        if (Y1 === 1'b1 || Y1 === 1'bz) begin
            errors++;
            $display("FAIL x_carry: got %b, expected 0 or x", Y1);
        end else begin
            $display("x_carry: Y1=%b", Y1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({Y1, Y0} !== 2'b00) begin
            errors++;
            $display("FAIL x_reset: got %b, expected 00", {Y1, Y0});
        end else begin
            $display("x_reset: Y1Y0=%b", {Y1, Y0});
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {a, b, c} = 3'b000;
        test_reset();
        test_gray();
        test_exhaustive();
        test_mid_reset();
        test_simultaneous();
        test_random();
        test_x();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
